// File: rtl/onehot_encoder_seq_pkg.sv
// Shared types and constants for the sequential one-hot encoder.
package onehot_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_LOAD  = 2'b00,
        MODE_ROTL  = 2'b01,
        MODE_ROTR  = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_e;

    // True when an index addresses an existing bit of a vector of width out_w.
    function automatic logic idx_in_range(input int unsigned idx_val, input int unsigned out_w);
        return (idx_val < out_w);
    endfunction

endpackage

// File: rtl/onehot_encoder_seq_if.sv
// Command and result channels of the sequential one-hot encoder.
interface onehot_encoder_seq_if
    import onehot_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) ();

    logic              in_valid;
    logic              in_ready;
    logic [MODE_W-1:0] in_mode;
    logic [IN_W-1:0]   in_idx;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_onehot;
    logic [IN_W-1:0]   out_idx;
    logic              out_err;

    // Command issuer and result consumer side.
    modport master (
        output in_valid, in_mode, in_idx, out_ready,
        input  in_ready, out_valid, out_onehot, out_idx, out_err
    );

    // Encoder side.
    modport slave (
        input  in_valid, in_mode, in_idx, out_ready,
        output in_ready, out_valid, out_onehot, out_idx, out_err
    );

endinterface

// File: rtl/onehot_encoder_seq_core.sv
// Combinational next-state logic: applies one command to the current one-hot state.
module onehot_core
    import onehot_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) (
    input  logic [OUT_W-1:0] cur,
    input  logic [IN_W-1:0]  cur_idx,
    input  mode_e            mode,
    input  logic [IN_W-1:0]  idx,
    output logic [OUT_W-1:0] next_cur,
    output logic [IN_W-1:0]  next_cur_idx,
    output logic             err
);

    // Highest legal position; wraps are modulo OUT_W, not modulo 2^IN_W.
    localparam logic [IN_W-1:0]  LAST_IDX = IN_W'(OUT_W - 1);
    localparam logic [OUT_W-1:0] ONE_VEC  = {{(OUT_W-1){1'b0}}, 1'b1};

    logic cur_empty_s;
    logic idx_ok_s;

    // Qualifiers shared by the command decode below.
    always_comb begin
        cur_empty_s = (cur == {OUT_W{1'b0}});
        idx_ok_s    = idx_in_range(32'(idx), 32'(OUT_W));
    end

    // Command decode; an empty state cannot rotate and is left untouched.
    always_comb begin
        next_cur     = cur;
        next_cur_idx = cur_idx;
        err          = 1'b0;
        case (mode)
            MODE_LOAD: begin
                if (idx_ok_s) begin
                    next_cur     = ONE_VEC << idx;
                    next_cur_idx = idx;
                    err          = 1'b0;
                end else begin
                    next_cur     = {OUT_W{1'b0}};
                    next_cur_idx = {IN_W{1'b0}};
                    err          = 1'b1;
                end
            end
            MODE_ROTL: begin
                if (cur_empty_s) begin
                    err = 1'b1;
                end else begin
                    next_cur     = {cur[OUT_W-2:0], cur[OUT_W-1]};
                    next_cur_idx = (cur_idx == LAST_IDX) ? {IN_W{1'b0}} : cur_idx + IN_W'(1);
                    err          = 1'b0;
                end
            end
            MODE_ROTR: begin
                if (cur_empty_s) begin
                    err = 1'b1;
                end else begin
                    next_cur     = {cur[0], cur[OUT_W-1:1]};
                    next_cur_idx = (cur_idx == {IN_W{1'b0}}) ? LAST_IDX : cur_idx - IN_W'(1);
                    err          = 1'b0;
                end
            end
            MODE_CLEAR: begin
                next_cur     = {OUT_W{1'b0}};
                next_cur_idx = {IN_W{1'b0}};
                err          = 1'b0;
            end
            default: begin
                next_cur     = {OUT_W{1'b0}};
                next_cur_idx = {IN_W{1'b0}};
                err          = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/onehot_encoder_seq.sv
// Registered one-hot encoder with rotate/clear commands behind valid/ready handshakes.
module onehot_encoder_seq
    import onehot_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) (
    input logic                clk,
    input logic                rst_n,
    onehot_encoder_seq_if.slave bus
);

    generate
        if (IN_W < 1 || IN_W > 8 || OUT_W < 2 || OUT_W > (1 << IN_W)) begin : g_bad_params
            $error("onehot_encoder_seq: illegal IN_W/OUT_W combination");
        end
    endgenerate

    logic [OUT_W-1:0] cur_r;
    logic [IN_W-1:0]  cur_idx_r;
    logic             out_valid_r;
    logic             out_err_r;

    logic [OUT_W-1:0] next_cur_s;
    logic [IN_W-1:0]  next_cur_idx_s;
    logic             err_s;
    logic             in_ready_s;
    logic             accept_s;

    onehot_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .cur          (cur_r),
        .cur_idx      (cur_idx_r),
        .mode         (mode_e'(bus.in_mode)),
        .idx          (bus.in_idx),
        .next_cur     (next_cur_s),
        .next_cur_idx (next_cur_idx_s),
        .err          (err_s)
    );

    // Single-entry output stage: accept when empty or when the held result drains this cycle.
    always_comb begin
        in_ready_s = rst_n & (~out_valid_r | bus.out_ready);
        accept_s   = bus.in_valid & in_ready_s;
    end

    // State doubles as the result register, so rotates always chain on the last accepted command.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_r       <= {OUT_W{1'b0}};
            cur_idx_r   <= {IN_W{1'b0}};
            out_err_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            cur_r       <= next_cur_s;
            cur_idx_r   <= next_cur_idx_s;
            out_err_r   <= err_s;
            out_valid_r <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_onehot = cur_r;
    assign bus.out_idx    = cur_idx_r;
    assign bus.out_err    = out_err_r;

endmodule

// File: tb/tb_onehot_encoder_seq.sv
// Bench for onehot_encoder_seq: a 16-wide and a 10-wide instance driven with identical
// stimulus, each compared against a position-based reference model.
module tb_onehot_encoder_seq;
    import onehot_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_mode = 2'b00;
    logic [3:0] in_idx = 4'd0;
    logic       out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    onehot_encoder_seq_if #(.IN_W(4), .OUT_W(16)) bus16 ();
    onehot_encoder_seq_if #(.IN_W(4), .OUT_W(10)) bus10 ();

    assign bus16.in_valid  = in_valid;
    assign bus16.in_mode   = in_mode;
    assign bus16.in_idx    = in_idx;
    assign bus16.out_ready = out_ready;
    assign bus10.in_valid  = in_valid;
    assign bus10.in_mode   = in_mode;
    assign bus10.in_idx    = in_idx;
    assign bus10.out_ready = out_ready;

    onehot_encoder_seq #(.IN_W(4), .OUT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    onehot_encoder_seq #(.IN_W(4), .OUT_W(10)) dut10 (.clk(clk), .rst_n(rst_n), .bus(bus10));

    // Observed outputs, widened to 16 bits so both instances share one compare loop.
    logic [15:0] obs_oh    [2];
    logic [3:0]  obs_idx   [2];
    logic        obs_err   [2];
    logic        obs_valid [2];
    logic        obs_rdy   [2];
    assign obs_oh[0]    = bus16.out_onehot;
    assign obs_oh[1]    = {6'd0, bus10.out_onehot};
    assign obs_idx[0]   = bus16.out_idx;
    assign obs_idx[1]   = bus10.out_idx;
    assign obs_err[0]   = bus16.out_err;
    assign obs_err[1]   = bus10.out_err;
    assign obs_valid[0] = bus16.out_valid;
    assign obs_valid[1] = bus10.out_valid;
    assign obs_rdy[0]   = bus16.in_ready;
    assign obs_rdy[1]   = bus10.in_ready;

    // Reference model: the active bit as a position (-1 = empty), plus the pending result.
    int ow [2] = '{16, 10};
    int state_pos [2];
    int res_pos [2];
    bit res_err [2];
    bit exp_valid;
    bit exp_rdy;
    bit rdy_seen [2];
    bit last_acc;

    function automatic logic [15:0] exp_oh(input int d);
        logic [15:0] one = 16'd1;
        return (res_pos[d] < 0) ? 16'd0 : (one << res_pos[d]);
    endfunction

    function automatic logic [3:0] exp_idx(input int d);
        return (res_pos[d] < 0) ? 4'd0 : 4'(res_pos[d]);
    endfunction

    task automatic model_apply(input int d, input int mode, input int idx);
        case (mode)
            0: begin
                if (idx < ow[d]) begin state_pos[d] = idx; res_err[d] = 1'b0; end
                else begin state_pos[d] = -1; res_err[d] = 1'b1; end
            end
            1: begin
                if (state_pos[d] < 0) res_err[d] = 1'b1;
                else begin state_pos[d] = (state_pos[d] + 1) % ow[d]; res_err[d] = 1'b0; end
            end
            2: begin
                if (state_pos[d] < 0) res_err[d] = 1'b1;
                else begin state_pos[d] = (state_pos[d] + ow[d] - 1) % ow[d]; res_err[d] = 1'b0; end
            end
            default: begin state_pos[d] = -1; res_err[d] = 1'b0; end
        endcase
        res_pos[d] = state_pos[d];
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            state_pos[d] = -1;
            res_pos[d]   = -1;
            res_err[d]   = 1'b0;
        end
        exp_valid = 1'b0;
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge, return at the next falling edge.
    task automatic cycle(input bit v, input int mode, input int idx, input bit ordy);
        in_valid  = v;
        in_mode   = 2'(mode);
        in_idx    = 4'(idx);
        out_ready = ordy;
        exp_rdy   = (rst_n === 1'b1) && (!exp_valid || ordy);
        last_acc  = v && exp_rdy;
        #1;
        for (int d = 0; d < 2; d++) rdy_seen[d] = obs_rdy[d];
        @(posedge clk);
        if (rst_n !== 1'b1) begin
            model_reset();
        end else if (last_acc) begin
            for (int d = 0; d < 2; d++) model_apply(d, mode, idx);
            exp_valid = 1'b1;
        end else if (ordy) begin
            exp_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle(1'b1, 0, 3, 1'b1);
        cycle(1'b0, 0, 0, 1'b1);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_valid[d] !== 1'b0 || obs_oh[d] !== 16'd0 || obs_idx[d] !== 4'd0 || obs_err[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: valid=%0b oh=%h idx=%0d err=%0b, required all zero",
                         d, obs_valid[d], obs_oh[d], obs_idx[d], obs_err[d]);
            end
            checks++;
            if (rdy_seen[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_in_ready dut%0d: got %0b, required 0", d, rdy_seen[d]);
            end
        end
        rst_n = 1'b1;
        cycle(1'b0, 0, 0, 1'b1);
    endtask

    task automatic test_load_sweep();
        logic [15:0] one = 16'd1;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, MODE_LOAD, i, 1'b1);
            checks++;
            if (obs_valid[0] !== 1'b1 || obs_oh[0] !== (one << i) || obs_idx[0] !== 4'(i) || obs_err[0] !== 1'b0) begin
                errors++;
                $display("FAIL load_sweep idx=%0d: valid=%0b oh=%h idx=%0d err=%0b, required 1 %h %0d 0",
                         i, obs_valid[0], obs_oh[0], obs_idx[0], obs_err[0], one << i, i);
            end
            checks++;
            if (obs_valid[1] !== 1'b1 || obs_oh[1] !== exp_oh(1) || obs_idx[1] !== exp_idx(1) || obs_err[1] !== res_err[1]) begin
                errors++;
                $display("FAIL load_sweep_w10 idx=%0d: oh=%h idx=%0d err=%0b, required %h %0d %0b",
                         i, obs_oh[1], obs_idx[1], obs_err[1], exp_oh(1), exp_idx(1), res_err[1]);
            end
        end
        cycle(1'b0, 0, 0, 1'b1);
        checks++;
        if (obs_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL drain_valid: got %0b, required 0", obs_valid[0]);
        end
    endtask

    task automatic test_rotate_wrap();
        int modes [4] = '{0, 1, 2, 2};
        logic [15:0] want_oh [4] = '{16'h8000, 16'h0001, 16'h8000, 16'h4000};
        logic [3:0]  want_idx [4] = '{4'd15, 4'd0, 4'd15, 4'd14};
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, modes[k], 15, 1'b1);
            checks++;
            if (obs_oh[0] !== want_oh[k] || obs_idx[0] !== want_idx[k] || obs_err[0] !== 1'b0) begin
                errors++;
                $display("FAIL rotate_wrap step%0d: oh=%h idx=%0d err=%0b, required %h %0d 0",
                         k, obs_oh[0], obs_idx[0], obs_err[0], want_oh[k], want_idx[k]);
            end
            checks++;
            if (obs_oh[1] !== exp_oh(1) || obs_idx[1] !== exp_idx(1) || obs_err[1] !== res_err[1]) begin
                errors++;
                $display("FAIL rotate_wrap_w10 step%0d: oh=%h idx=%0d err=%0b, required %h %0d %0b",
                         k, obs_oh[1], obs_idx[1], obs_err[1], exp_oh(1), exp_idx(1), res_err[1]);
            end
        end
    endtask

    task automatic test_errors_nonpow2();
        int modes [4] = '{0, 1, 0, 1};
        int idxs  [4] = '{12, 0, 9, 0};
        logic [15:0] want_oh  [4] = '{16'h000, 16'h000, 16'h200, 16'h001};
        logic [3:0]  want_idx [4] = '{4'd0, 4'd0, 4'd9, 4'd0};
        logic        want_err [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, modes[k], idxs[k], 1'b1);
            checks++;
            if (obs_oh[1] !== want_oh[k] || obs_idx[1] !== want_idx[k] || obs_err[1] !== want_err[k]) begin
                errors++;
                $display("FAIL nonpow2 step%0d: oh=%h idx=%0d err=%0b, required %h %0d %0b",
                         k, obs_oh[1], obs_idx[1], obs_err[1], want_oh[k], want_idx[k], want_err[k]);
            end
            checks++;
            if (obs_oh[0] !== exp_oh(0) || obs_idx[0] !== exp_idx(0) || obs_err[0] !== res_err[0]) begin
                errors++;
                $display("FAIL nonpow2_w16 step%0d: oh=%h idx=%0d err=%0b, required %h %0d %0b",
                         k, obs_oh[0], obs_idx[0], obs_err[0], exp_oh(0), exp_idx(0), res_err[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        cycle(1'b1, MODE_LOAD, 3, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, MODE_LOAD, 7, 1'b0);
            checks++;
            if (rdy_seen[0] !== 1'b0 || obs_valid[0] !== 1'b1 || obs_oh[0] !== 16'h0008 || obs_idx[0] !== 4'd3) begin
                errors++;
                $display("FAIL backpressure_hold cyc%0d: rdy=%0b valid=%0b oh=%h idx=%0d, required 0 1 0008 3",
                         k, rdy_seen[0], obs_valid[0], obs_oh[0], obs_idx[0]);
            end
        end
        cycle(1'b1, MODE_LOAD, 7, 1'b1);
        checks++;
        if (rdy_seen[0] !== 1'b1 || obs_valid[0] !== 1'b1 || obs_oh[0] !== 16'h0080 || obs_idx[0] !== 4'd7) begin
            errors++;
            $display("FAIL backpressure_release: rdy=%0b valid=%0b oh=%h idx=%0d, required 1 1 0080 7",
                     rdy_seen[0], obs_valid[0], obs_oh[0], obs_idx[0]);
        end
        cycle(1'b0, 0, 0, 1'b1);
        checks++;
        if (obs_valid[0] !== 1'b0 || obs_valid[1] !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_no_dup: valid=%0b/%0b, required 0/0", obs_valid[0], obs_valid[1]);
        end
    endtask

    task automatic test_reset_midstream();
        cycle(1'b1, MODE_LOAD, 5, 1'b0);
        checks++;
        if (obs_valid[0] !== 1'b1 || obs_oh[0] !== 16'h0020) begin
            errors++;
            $display("FAIL midreset_pending: valid=%0b oh=%h, required 1 0020", obs_valid[0], obs_oh[0]);
        end
        rst_n = 1'b0;
        cycle(1'b0, 0, 0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_valid[d] !== 1'b0 || obs_oh[d] !== 16'd0 || obs_idx[d] !== 4'd0 || obs_err[d] !== 1'b0 || rdy_seen[d] !== 1'b0) begin
                errors++;
                $display("FAIL midreset_outputs dut%0d: valid=%0b oh=%h idx=%0d err=%0b rdy=%0b, required all zero",
                         d, obs_valid[d], obs_oh[d], obs_idx[d], obs_err[d], rdy_seen[d]);
            end
        end
        rst_n = 1'b1;
        cycle(1'b1, MODE_ROTL, 0, 1'b1);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_valid[d] !== 1'b1 || obs_oh[d] !== 16'd0 || obs_err[d] !== 1'b1) begin
                errors++;
                $display("FAIL midreset_rotl dut%0d: valid=%0b oh=%h err=%0b, required 1 0000 1",
                         d, obs_valid[d], obs_oh[d], obs_err[d]);
            end
        end
    endtask

    task automatic test_random_stream();
        int issued = 0;
        int budget = 0;
        while (issued < 200 && budget < 3000) begin
            bit v    = ($urandom_range(0, 3) != 0);
            bit ordy = ($urandom_range(0, 9) < 7);
            int mode = $urandom_range(0, 3);
            int idx  = $urandom_range(0, 15);
            budget++;
            cycle(v, mode, idx, ordy);
            if (last_acc) issued++;
            for (int d = 0; d < 2; d++) begin
                logic [3:0] pos;
                checks++;
                if (rdy_seen[d] !== exp_rdy) begin
                    errors++;
                    $display("FAIL stream_in_ready dut%0d cyc%0d: got %0b, required %0b", d, budget, rdy_seen[d], exp_rdy);
                end
                checks++;
                if (obs_valid[d] !== exp_valid) begin
                    errors++;
                    $display("FAIL stream_valid dut%0d cyc%0d: got %0b, required %0b", d, budget, obs_valid[d], exp_valid);
                end
                if (exp_valid) begin
                    checks++;
                    if (obs_oh[d] !== exp_oh(d) || obs_idx[d] !== exp_idx(d) || obs_err[d] !== res_err[d]) begin
                        errors++;
                        $display("FAIL stream_result dut%0d cyc%0d: oh=%h idx=%0d err=%0b, required %h %0d %0b",
                                 d, budget, obs_oh[d], obs_idx[d], obs_err[d], exp_oh(d), exp_idx(d), res_err[d]);
                    end
                end
                pos = obs_idx[d];
                checks++;
                if ($countones(obs_oh[d]) > 1 || (obs_oh[d] != 16'd0 && obs_oh[d][pos] !== 1'b1)) begin
                    errors++;
                    $display("FAIL stream_invariant dut%0d cyc%0d: oh=%h idx=%0d", d, budget, obs_oh[d], obs_idx[d]);
                end
            end
        end
        checks++;
        if (issued < 200) begin
            errors++;
            $display("FAIL stream_budget: issued %0d commands, required 200", issued);
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_load_sweep();
        test_rotate_wrap();
        test_errors_nonpow2();
        test_backpressure();
        test_reset_midstream();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
